// File: rtl/breadboard_sweeper_if.sv
// breadboard_sweeper_if: host and breadboard signals of the sweeper
//   master: host/bench side (drives start, expected-table writes, readback address and breadboard response f)
//   slave : sweeper side (drives stimulus w,x,y,z, readback data and sweep status)
interface breadboard_sweeper_if #(parameter int NF = 10);
    logic          start;
    logic          exp_we;
    logic [3:0]    exp_addr;
    logic [NF-1:0] exp_data;
    logic [3:0]    rd_addr;
    logic [NF-1:0] rd_data;
    logic          w, x, y, z;
    logic [NF-1:0] f;
    logic          busy, done, pass;
    logic [4:0]    err_count;
    logic          err_seen;
    logic [3:0]    first_err_row;
    modport master (
        output start, exp_we, exp_addr, exp_data, rd_addr, f,
        input  rd_data, w, x, y, z, busy, done, pass, err_count, err_seen, first_err_row
    );
    modport slave (
        input  start, exp_we, exp_addr, exp_data, rd_addr, f,
        output rd_data, w, x, y, z, busy, done, pass, err_count, err_seen, first_err_row
    );
endinterface

// File: rtl/breadboard_sweeper.sv
// breadboard_sweeper: walks a 4-input breadboard through rows 0..15, captures its NF outputs and checks them
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of breadboard_sweeper_if (start, expected-table write, readback, stimulus, status)
module breadboard_sweeper #(
    parameter int SETTLE = 4,
    parameter int NF     = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    breadboard_sweeper_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);
    state_t        state_q, state_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [4:0]    err_count_q, err_count_d;
    logic          err_seen_q, err_seen_d;
    logic [3:0]    first_err_row_q, first_err_row_d;
    logic          pass_q, pass_d;
    logic [NF-1:0] rd_data_q;
    logic [NF-1:0] exp_mem [16];
    logic [NF-1:0] cap_mem [16];
    logic          idle_like, mism;
    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign mism      = bus.f != exp_mem[row_q];
    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        cnt_d           = cnt_q;
        err_count_d     = err_count_q;
        err_seen_d      = err_seen_q;
        first_err_row_d = first_err_row_q;
        pass_d          = pass_q;
        case (state_q)
            IDLE, DONE: if (bus.start) begin
                state_d         = WAIT;
                row_d           = '0;
                cnt_d           = SETTLE_C;
                err_count_d     = '0;
                err_seen_d      = 1'b0;
                first_err_row_d = '0;
                pass_d          = 1'b0;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? SAMPLE : WAIT;
            end
            SAMPLE: begin
                err_count_d = err_count_q + {4'b0, mism};
                if (mism && !err_seen_q) begin
                    err_seen_d      = 1'b1;
                    first_err_row_d = row_q;
                end
                if (row_q == 4'd15) begin
                    state_d = DONE;
                    pass_d  = err_count_d == 5'd0;
                end else begin
                    state_d = WAIT;
                    row_d   = row_q + 4'd1;
                    cnt_d   = SETTLE_C;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            row_q           <= '0;
            cnt_q           <= '0;
            err_count_q     <= '0;
            err_seen_q      <= 1'b0;
            first_err_row_q <= '0;
            pass_q          <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            cnt_q           <= cnt_d;
            err_count_q     <= err_count_d;
            err_seen_q      <= err_seen_d;
            first_err_row_q <= first_err_row_d;
            pass_q          <= pass_d;
            rd_data_q       <= cap_mem[bus.rd_addr];
        end
    end
    // Tables are never cleared; capture rows survive a mid-sweep reset.
    always_ff @(posedge clk) begin
        if (!reset && idle_like && bus.exp_we)
            exp_mem[bus.exp_addr] <= bus.exp_data;
        if (!reset && state_q == SAMPLE)
            cap_mem[row_q] <= bus.f;
    end
    assign {bus.w, bus.x, bus.y, bus.z} = row_q;
    assign bus.busy          = (state_q == WAIT) || (state_q == SAMPLE);
    assign bus.done          = state_q == DONE;
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_count_q;
    assign bus.err_seen      = err_seen_q;
    assign bus.first_err_row = first_err_row_q;
    assign bus.rd_data       = rd_data_q;
endmodule

// File: tb/tb_breadboard_sweeper.sv
// tb_breadboard_sweeper: randomized self-checking bench for breadboard_sweeper
module tb_breadboard_sweeper;
    localparam int NF = 10;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    breadboard_sweeper_if #(.NF(NF)) bus_a ();
    breadboard_sweeper_if #(.NF(NF)) bus_b ();
    breadboard_sweeper #(.SETTLE(4), .NF(NF)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    breadboard_sweeper #(.SETTLE(1), .NF(NF)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    logic [NF-1:0] bb   [16];
    logic [NF-1:0] expv [16];
    int rec [0:200];
    int errors = 0;
    int checks = 0;
    logic [3:0] wxyz_a, wxyz_b;
    assign wxyz_a = {bus_a.w, bus_a.x, bus_a.y, bus_a.z};
    assign wxyz_b = {bus_b.w, bus_b.x, bus_b.y, bus_b.z};
    assign bus_a.f = bb[wxyz_a];
    assign bus_b.f = bb[wxyz_b];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void model(output int cnt, output int first);
        cnt = 0;
        first = 0;
        for (int r = 15; r >= 0; r--)
            if (expv[r] !== bb[r]) begin
                cnt++;
                first = r;
            end
    endfunction

    task automatic load_a;
        for (int r = 0; r < 16; r++) begin
            bus_a.exp_we = 1'b1;
            bus_a.exp_addr = 4'(r);
            bus_a.exp_data = expv[r];
            tick;
        end
        bus_a.exp_we = 1'b0;
    endtask

    task automatic sweep_a(input int s_at, input int we_at, input int rst_at, output int n, output bit hit_rst);
        bit overlap;
        overlap = 1'b0;
        hit_rst = 1'b0;
        bus_a.start = 1'b1;
        tick;
        bus_a.start = 1'b0;
        checks++;
        if (bus_a.busy !== 1'b1 || bus_a.done !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_start: busy=%b done=%b, expected busy=1 done=0", bus_a.busy, bus_a.done);
        end
        n = 0;
        rec[0] = int'(wxyz_a);
        while (bus_a.done !== 1'b1 && n < 200) begin
            bus_a.start = (n == s_at);
            bus_a.exp_we = (n == we_at);
            bus_a.exp_addr = 4'd0;
            bus_a.exp_data = '1;
            reset = (n == rst_at);
            tick;
            n++;
            bus_a.start = 1'b0;
            bus_a.exp_we = 1'b0;
            if (reset) begin
                reset = 1'b0;
                hit_rst = 1'b1;
                break;
            end
            rec[n] = int'(wxyz_a);
            if (bus_a.busy && bus_a.done) overlap = 1'b1;
        end
        checks++;
        if (overlap) begin
            errors++;
            $display("FAIL busy_done_overlap: busy and done seen high together, expected never");
        end
    endtask

    task automatic check_result(input string tag, input int n);
        int cnt, first;
        model(cnt, first);
        checks++;
        if (n !== 80) begin
            errors++;
            $display("FAIL %s_done_time: done after %0d cycles, expected 80", tag, n);
        end
        checks++;
        if (bus_a.err_count !== 5'(cnt) || bus_a.pass !== (cnt == 0) || bus_a.err_seen !== (cnt != 0)) begin
            errors++;
            $display("FAIL %s_status: err_count=%0d pass=%b err_seen=%b, expected %0d %b %b",
                     tag, bus_a.err_count, bus_a.pass, bus_a.err_seen, cnt, cnt == 0, cnt != 0);
        end
        if (cnt != 0) begin
            checks++;
            if (bus_a.first_err_row !== 4'(first)) begin
                errors++;
                $display("FAIL %s_first_err_row: got %0d, expected %0d", tag, bus_a.first_err_row, first);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        checks++;
        if (bus_a.rd_data !== '0 || bus_b.rd_data !== '0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h/%h, expected 0", bus_a.rd_data, bus_b.rd_data);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            checks++;
            if ({bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count, bus_a.err_seen, bus_a.first_err_row, wxyz_a} !== '0) begin
                errors++;
                $display("FAIL reset_idle: cycle %0d busy=%b done=%b pass=%b err_count=%0d err_seen=%b first=%0d wxyz=%b, expected all 0",
                         i, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count, bus_a.err_seen, bus_a.first_err_row, wxyz_a);
            end
        end
    endtask

    task automatic test_golden;
        int n, bad;
        bit hr;
        for (int r = 0; r < 16; r++) expv[r] = bb[r];
        load_a;
        sweep_a(-1, -1, -1, n, hr);
        check_result("golden", n);
        bad = -1;
        for (int k = 0; k < 80; k++) if (bad < 0 && rec[k] != k / 5) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL golden_stimulus: cycle %0d wxyz=%0d, expected %0d", bad, rec[bad], bad / 5);
        end
        checks++;
        if (wxyz_a !== 4'hF || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL golden_final: wxyz=%b busy=%b, expected 1111 0", wxyz_a, bus_a.busy);
        end
        bus_a.rd_addr = 4'd5;
        tick;
        checks++;
        if (bus_a.rd_data !== 10'h0C2) begin
            errors++;
            $display("FAIL readback_row5: got %h, expected 0c2", bus_a.rd_data);
        end
        for (int r = 0; r < 16; r++) begin
            bus_a.rd_addr = 4'(r);
            tick;
            checks++;
            if (bus_a.rd_data !== bb[r]) begin
                errors++;
                $display("FAIL readback_row%0d: got %h, expected %h", r, bus_a.rd_data, bb[r]);
            end
        end
    endtask

    task automatic test_errors;
        int n;
        bit hr;
        for (int r = 0; r < 16; r++) expv[r] = bb[r];
        expv[3][0] = ~expv[3][0];
        expv[12][0] = ~expv[12][0];
        load_a;
        sweep_a(-1, -1, -1, n, hr);
        check_result("flip_3_12", n);
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < 16; r++) begin
                expv[r] = bb[r];
                if ($urandom_range(3) == 0) expv[r] = bb[r] ^ NF'($urandom_range(1, (1 << NF) - 1));
            end
            if (t == 3) for (int r = 0; r < 16; r++) expv[r] = ~bb[r];
            load_a;
            sweep_a(-1, -1, -1, n, hr);
            check_result($sformatf("random%0d", t), n);
        end
    endtask

    task automatic test_mid_sweep;
        int n;
        bit hr;
        for (int r = 0; r < 16; r++) expv[r] = bb[r];
        load_a;
        sweep_a(10, 20, -1, n, hr);
        check_result("mid_pulses", n);
        sweep_a(-1, -1, -1, n, hr);
        check_result("mid_repeat", n);
    endtask

    task automatic test_reset_mid;
        int n;
        bit hr;
        expv[0] = ~bb[0];
        load_a;
        sweep_a(-1, -1, 30, n, hr);
        checks++;
        if (!hr || bus_a.busy !== 1'b0 || wxyz_a !== 4'b0 || bus_a.err_count !== 5'd0 || bus_a.done !== 1'b0 || bus_a.err_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: hit=%b busy=%b wxyz=%b err_count=%0d done=%b err_seen=%b, expected 1 0 0000 0 0 0",
                     hr, bus_a.busy, wxyz_a, bus_a.err_count, bus_a.done, bus_a.err_seen);
        end
        expv[0] = bb[0];
        load_a;
        sweep_a(-1, -1, -1, n, hr);
        check_result("after_reset", n);
    endtask

    task automatic test_settle1;
        int n, bad;
        for (int r = 0; r < 16; r++) begin
            bus_b.exp_we = 1'b1;
            bus_b.exp_addr = 4'(r);
            bus_b.exp_data = bb[r];
            tick;
        end
        bus_b.exp_we = 1'b0;
        bus_b.start = 1'b1;
        tick;
        bus_b.start = 1'b0;
        n = 0;
        rec[0] = int'(wxyz_b);
        while (bus_b.done !== 1'b1 && n < 200) begin
            tick;
            n++;
            rec[n] = int'(wxyz_b);
        end
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL settle1_done_time: done after %0d cycles, expected 32", n);
        end
        bad = -1;
        for (int k = 0; k < 32; k++) if (bad < 0 && rec[k] != k / 2) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL settle1_stimulus: cycle %0d wxyz=%0d, expected %0d", bad, rec[bad], bad / 2);
        end
        checks++;
        if (bus_b.pass !== 1'b1 || bus_b.err_count !== 5'd0) begin
            errors++;
            $display("FAIL settle1_pass: pass=%b err_count=%0d, expected 1 0", bus_b.pass, bus_b.err_count);
        end
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.exp_we = 1'b0; bus_a.exp_addr = '0; bus_a.exp_data = '0; bus_a.rd_addr = '0;
        bus_b.start = 1'b0; bus_b.exp_we = 1'b0; bus_b.exp_addr = '0; bus_b.exp_data = '0; bus_b.rd_addr = '0;
        for (int r = 0; r < 16; r++) bb[r] = NF'($urandom);
        bb[5] = 10'h0C2;
        if (bb[0] == 10'h3FF) bb[0] = 10'h155;
        test_reset;
        test_golden;
        test_errors;
        test_mid_sweep;
        test_reset_mid;
        test_settle1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
